// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: Cpu, Vdp and RAM side signals of the shared RAM port arbiter.
// The statistics counters exist only when BUS_ARBITER_STATS_EN is defined.
interface bus_arbiter_if;
   logic        cpuReq;
   logic        cpuWrite;
   logic [15:0] cpuAddress;
   logic [7:0]  cpuDataIn;
   logic        cpuAck;
   logic [7:0]  cpuDataOut;
   logic        vdpReq;
   logic [15:0] vdpAddress;
   logic        vdpAck;
   logic [7:0]  vdpDataOut;
   logic [15:0] memAddress;
   logic        memRead;
   logic        memWrite;
   logic [7:0]  memDataOut;
   logic [7:0]  memDataIn;
`ifdef BUS_ARBITER_STATS_EN
   logic [15:0] cpuGrantCount;
   logic [15:0] vdpGrantCount;
   logic [15:0] cpuStallCount;
`endif

   // arbiter side
   modport slave (
      input  cpuReq, cpuWrite, cpuAddress, cpuDataIn, vdpReq, vdpAddress, memDataIn,
      output cpuAck, cpuDataOut, vdpAck, vdpDataOut,
      output memAddress, memRead, memWrite, memDataOut
`ifdef BUS_ARBITER_STATS_EN
      , output cpuGrantCount, vdpGrantCount, cpuStallCount
`endif
   );

   // requesters and RAM side
   modport master (
      output cpuReq, cpuWrite, cpuAddress, cpuDataIn, vdpReq, vdpAddress, memDataIn,
      input  cpuAck, cpuDataOut, vdpAck, vdpDataOut,
      input  memAddress, memRead, memWrite, memDataOut
`ifdef BUS_ARBITER_STATS_EN
      , input cpuGrantCount, vdpGrantCount, cpuStallCount
`endif
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one synchronous RAM port between the Cpu and the Vdp fetch
// path. Each transaction takes four cycles; read data returns with a one-cycle ack.
// Optional statistics counters are enabled by defining BUS_ARBITER_STATS_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrate; latch the winner into the owner register
// ISSUE   | RAM strobe (memRead or memWrite) high for this cycle only
// CAPTURE | RAM read data valid; register it into the owner's DataOut
// ACK     | owner's ack pulse
module bus_arbiter #(
   parameter int MAX_CPU_WAIT = 8,
   parameter bit ROM_PROTECT  = 1'b1
) (
   input logic         clk,
   input logic         reset,
   bus_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] ACK     = 2'd3;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_CPU_WAIT);

   logic [1:0]  state;
   logic        owner_vdp;
   logic        owner_write;
   logic [15:0] owner_addr;
   logic [7:0]  owner_data;
   logic [7:0]  cpu_wait;

   logic        cpu_ack;
   logic        vdp_ack;
   logic [7:0]  cpu_data;
   logic [7:0]  vdp_data;
   logic        mem_read;
   logic        mem_write;

   logic        grant_vdp;
   logic        grant_cpu;
   logic        cpu_owns;
   logic        wait_inc;
   logic        rom_hit;

   // arbitration: Vdp has priority until the Cpu has waited MAX_CPU_WAIT cycles
   always_comb begin
      grant_vdp = 1'b0;
      grant_cpu = 1'b0;
      if (state == IDLE) begin
         if (bus.vdpReq && (cpu_wait < WAIT_LIMIT)) begin
            grant_vdp = 1'b1;
         end else if (bus.cpuReq) begin
            grant_cpu = 1'b1;
         end else if (bus.vdpReq) begin
            grant_vdp = 1'b1;
         end
      end
      cpu_owns = (state != IDLE) && !owner_vdp;
      wait_inc = bus.cpuReq && !cpu_owns && !grant_cpu && (cpu_wait < WAIT_LIMIT);
      rom_hit  = ROM_PROTECT && (bus.cpuAddress[15:14] == 2'b00);
   end

   // transaction sequencer; any grant starts a fixed four-cycle pass
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (grant_vdp || grant_cpu) state <= ISSUE;
            ISSUE:   state <= CAPTURE;
            CAPTURE: state <= ACK;
            default: state <= IDLE;
         endcase
      end
   end

   // owner register: later changes on the request inputs do not reach RAM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_vdp   <= 1'b0;
         owner_write <= 1'b0;
         owner_addr  <= '0;
         owner_data  <= '0;
      end else if (grant_vdp) begin
         owner_vdp   <= 1'b1;
         owner_write <= 1'b0;
         owner_addr  <= bus.vdpAddress;
      end else if (grant_cpu) begin
         owner_vdp   <= 1'b0;
         owner_write <= bus.cpuWrite;
         owner_addr  <= bus.cpuAddress;
         owner_data  <= bus.cpuDataIn;
      end
   end

   // RAM strobes are registered so they are high only during ISSUE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         mem_read  <= grant_vdp || (grant_cpu && !bus.cpuWrite);
         mem_write <= grant_cpu && bus.cpuWrite && !rom_hit;
      end
   end

   // read data capture and ack pulses; acks land in the ACK cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_data <= '0;
         vdp_data <= '0;
         cpu_ack  <= 1'b0;
         vdp_ack  <= 1'b0;
      end else begin
         cpu_ack <= (state == CAPTURE) && !owner_vdp;
         vdp_ack <= (state == CAPTURE) && owner_vdp;
         if ((state == CAPTURE) && !owner_write) begin
            if (owner_vdp) vdp_data <= bus.memDataIn;
            else           cpu_data <= bus.memDataIn;
         end
      end
   end

   // Cpu starvation counter, saturating, cleared on a Cpu grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_wait <= '0;
      end else if (grant_cpu) begin
         cpu_wait <= '0;
      end else if (wait_inc) begin
         cpu_wait <= cpu_wait + 8'd1;
      end
   end

   assign bus.cpuAck     = cpu_ack;
   assign bus.vdpAck     = vdp_ack;
   assign bus.cpuDataOut = cpu_data;
   assign bus.vdpDataOut = vdp_data;
   assign bus.memAddress = owner_addr;
   assign bus.memDataOut = owner_data;
   assign bus.memRead    = mem_read;
   assign bus.memWrite   = mem_write;

`ifdef BUS_ARBITER_STATS_EN
   logic [15:0] cpu_grant_cnt;
   logic [15:0] vdp_grant_cnt;
   logic [15:0] cpu_stall_cnt;

   // saturating grant and stall statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_grant_cnt <= '0;
         vdp_grant_cnt <= '0;
         cpu_stall_cnt <= '0;
      end else begin
         if (grant_cpu && (cpu_grant_cnt != 16'hFFFF)) cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
         if (grant_vdp && (vdp_grant_cnt != 16'hFFFF)) vdp_grant_cnt <= vdp_grant_cnt + 16'd1;
         if (wait_inc && (cpu_stall_cnt != 16'hFFFF))  cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
   end

   assign bus.cpuGrantCount = cpu_grant_cnt;
   assign bus.vdpGrantCount = vdp_grant_cnt;
   assign bus.cpuStallCount = cpu_stall_cnt;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a queue-based scoreboard for bus_arbiter.
module tb_bus_arbiter;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   bus_arbiter_if bus ();

   bus_arbiter #(.MAX_CPU_WAIT(8), .ROM_PROTECT(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous RAM model: one-cycle read latency
   logic [7:0] ram [0:65535];
   logic [7:0] rd_q;
   always @(posedge clk) begin
      if (bus.memWrite) ram[bus.memAddress] <= bus.memDataOut;
      if (bus.memRead)  rd_q <= ram[bus.memAddress];
   end
   assign bus.memDataIn = rd_q;

   logic [7:0]  exp_cpu [$];
   logic [7:0]  exp_vdp [$];
   logic [23:0] exp_wr  [$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops and compares whenever the DUT presents an ack or write strobe
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.cpuAck && bus.vdpAck) check("ack_exclusive", 1, 0);
         if (bus.cpuAck) begin
            if (exp_cpu.size() == 0) check("cpu_unexpected_ack", 1, 0);
            else check("cpu_data", int'(bus.cpuDataOut), int'(exp_cpu.pop_front()));
         end
         if (bus.vdpAck) begin
            if (exp_vdp.size() == 0) check("vdp_unexpected_ack", 1, 0);
            else check("vdp_data", int'(bus.vdpDataOut), int'(exp_vdp.pop_front()));
         end
         if (bus.memWrite) begin
            if (exp_wr.size() == 0) check("unexpected_mem_write", int'(bus.memAddress), -1);
            else check("mem_write", int'({bus.memAddress, bus.memDataOut}), int'(exp_wr.pop_front()));
         end
      end
   end

   task automatic cpu_txn(input string name, input logic wr, input logic [15:0] addr,
                          input logic [7:0] data, input logic [7:0] exp_data,
                          input logic exp_memwr);
      int n;
      int rd_cyc;
      int wr_cyc;
      bit got;
      exp_cpu.push_back(exp_data);
      if (wr && exp_memwr) exp_wr.push_back({addr, data});
      @(negedge clk);
      bus.cpuReq     = 1'b1;
      bus.cpuWrite   = wr;
      bus.cpuAddress = addr;
      bus.cpuDataIn  = data;
      n = 0; rd_cyc = -1; wr_cyc = -1; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.memRead  && rd_cyc < 0) rd_cyc = n;
         if (bus.memWrite && wr_cyc < 0) wr_cyc = n;
         if (bus.cpuAck) got = 1'b1;
      end
      bus.cpuReq = 1'b0;
      check({name, "_ack_cycle"}, n, 3);
      check({name, "_read_cycle"}, rd_cyc, wr ? -1 : 1);
      check({name, "_write_cycle"}, wr_cyc, (wr && exp_memwr) ? 1 : -1);
   endtask

   task automatic vdp_txn(input string name, input logic [15:0] addr, input logic [7:0] exp_data);
      int n;
      int rd_cyc;
      bit got;
      exp_vdp.push_back(exp_data);
      @(negedge clk);
      bus.vdpReq     = 1'b1;
      bus.vdpAddress = addr;
      n = 0; rd_cyc = -1; got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.memRead && rd_cyc < 0) rd_cyc = n;
         if (bus.vdpAck) got = 1'b1;
      end
      bus.vdpReq = 1'b0;
      check({name, "_ack_cycle"}, n, 3);
      check({name, "_read_cycle"}, rd_cyc, 1);
   endtask

   task automatic check_cleared(input string name);
      check({name, "_cpuAck"}, int'(bus.cpuAck), 0);
      check({name, "_vdpAck"}, int'(bus.vdpAck), 0);
      check({name, "_memRead"}, int'(bus.memRead), 0);
      check({name, "_memWrite"}, int'(bus.memWrite), 0);
      check({name, "_memAddress"}, int'(bus.memAddress), 0);
      check({name, "_memDataOut"}, int'(bus.memDataOut), 0);
      check({name, "_cpuDataOut"}, int'(bus.cpuDataOut), 0);
      check({name, "_vdpDataOut"}, int'(bus.vdpDataOut), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int vack1;
      int vack2;
      int cack;
      int stray;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.cpuReq = 1'b0; bus.cpuWrite = 1'b0; bus.cpuAddress = '0; bus.cpuDataIn = '0;
      bus.vdpReq = 1'b0; bus.vdpAddress = '0;
      ram[16'h4000] = 8'hA5;
      ram[16'h2000] = 8'h11;
      ram[16'h2001] = 8'h22;
      ram[16'h0010] = 8'h55;
      ram[16'h8001] = 8'h00;

      repeat (3) @(negedge clk);
      check_cleared("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single requester traffic, ROM window protection and its boundary
      cpu_txn("cpu_rd_4000", 1'b0, 16'h4000, 8'h00, 8'hA5, 1'b0);
      cpu_txn("cpu_wr_8001", 1'b1, 16'h8001, 8'h3C, 8'hA5, 1'b1);
      cpu_txn("cpu_rd_8001", 1'b0, 16'h8001, 8'h00, 8'h3C, 1'b0);
      cpu_txn("cpu_wr_rom",  1'b1, 16'h0010, 8'hFF, 8'h3C, 1'b0);
      cpu_txn("cpu_rd_rom",  1'b0, 16'h0010, 8'h00, 8'h55, 1'b0);
      cpu_txn("cpu_wr_4000", 1'b1, 16'h4000, 8'h5A, 8'h55, 1'b1);
      cpu_txn("cpu_rd_4000b", 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b0);

      // both requesting continuously: two Vdp grants, then the starved Cpu
      exp_vdp.push_back(8'h11);
      exp_vdp.push_back(8'h11);
      exp_cpu.push_back(8'h5A);
      @(negedge clk);
      bus.cpuReq = 1'b1; bus.cpuWrite = 1'b0; bus.cpuAddress = 16'h4000;
      bus.vdpReq = 1'b1; bus.vdpAddress = 16'h2000;
      n = 0; vack1 = -1; vack2 = -1; cack = -1;
      while (cack < 0 && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.vdpAck) begin
            if (vack1 < 0) vack1 = n;
            else if (vack2 < 0) vack2 = n;
         end
         if (bus.cpuAck) cack = n;
      end
      bus.cpuReq = 1'b0; bus.vdpReq = 1'b0;
      check("starve_vdp_ack1", vack1, 3);
      check("starve_vdp_ack2", vack2, 7);
      check("starve_cpu_ack", cack, 11);

      // wait counter cleared: Vdp wins the next simultaneous request again
      exp_vdp.push_back(8'h22);
      exp_cpu.push_back(8'h3C);
      @(negedge clk);
      bus.cpuReq = 1'b1; bus.cpuWrite = 1'b0; bus.cpuAddress = 16'h8001;
      bus.vdpReq = 1'b1; bus.vdpAddress = 16'h2001;
      n = 0; vack1 = -1; cack = -1;
      while (cack < 0 && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.vdpAck && vack1 < 0) begin
            vack1 = n;
            bus.vdpReq = 1'b0;
         end
         if (bus.cpuAck) cack = n;
      end
      bus.cpuReq = 1'b0; bus.vdpReq = 1'b0;
      check("cleared_vdp_ack", vack1, 3);
      check("cleared_cpu_ack", cack, 7);

      // reset during CAPTURE of a Vdp read drops the transaction
      @(negedge clk);
      bus.vdpReq = 1'b1; bus.vdpAddress = 16'h2000;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bus.vdpReq = 1'b0;
      #1;
      check_cleared("reset_capture");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.vdpAck || bus.cpuAck) stray++;
      end
      check("reset_no_ack", stray, 0);

      // traffic after reset: 3 Cpu and 5 Vdp transactions
      vdp_txn("vdp_after_reset", 16'h2000, 8'h11);
      for (int i = 0; i < 3; i++) cpu_txn("cpu_loop", 1'b0, 16'h8001, 8'h00, 8'h3C, 1'b0);
      for (int i = 0; i < 4; i++) vdp_txn("vdp_loop", 16'h2001, 8'h22);

`ifdef BUS_ARBITER_STATS_EN
      check("cpu_grant_count", int'(bus.cpuGrantCount), 3);
      check("vdp_grant_count", int'(bus.vdpGrantCount), 5);
      check("cpu_stall_count", int'(bus.cpuStallCount), 0);
`endif

      repeat (3) @(negedge clk);
      check("cpu_queue_drained", exp_cpu.size(), 0);
      check("vdp_queue_drained", exp_vdp.size(), 0);
      check("wr_queue_drained", exp_wr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single synchronous RAM port between the Cpu and the Vdp's memory fetch path. It arbitrates per transaction, sequences the RAM's one-cycle read latency, and returns read data with a one-cycle acknowledge pulse. It also blocks Cpu writes to the ROM window. It sits between the Cpu/Vdp and Ram in top and replaces the direct Cpu-to-Ram wiring.

Parameters:
MAX_CPU_WAIT, 8, stall cycles a pending Cpu request tolerates before it overrides Vdp priority (1..255)
ROM_PROTECT, 1, when 1, Cpu writes with address[15:14]==2'b00 are acknowledged but never reach RAM

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpuReq  input  1  Cpu transaction request, held until cpuAck
cpuWrite  input  1  1=write, 0=read; sampled with cpuReq
cpuAddress  input  16  Cpu address
cpuDataIn  input  8  Cpu write data
cpuAck  output  1  one-cycle transaction-complete pulse
cpuDataOut  output  8  Cpu read data, valid with cpuAck, held until next Cpu read ack
vdpReq  input  1  Vdp read request, held until vdpAck
vdpAddress  input  16  Vdp read address
vdpAck  output  1  one-cycle completion pulse
vdpDataOut  output  8  Vdp read data, valid with vdpAck, held until next Vdp ack
memAddress  output  16  RAM address
memRead  output  1  RAM read strobe
memWrite  output  1  RAM write enable
memDataOut  output  8  RAM write data
memDataIn  input  8  RAM read data, valid the cycle after memRead

Behaviour:
- The block is clocked and reset as decided for this block: one clock, clk; reset is asynchronous and active-high. Reset forces IDLE and clears all outputs, the owner register and the wait counter. An in-flight transaction is dropped with no ack. Requesters re-request after reset.
- FSM states: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. A transaction takes a fixed 4 cycles. Back-to-back transactions can start every 4 cycles.
- IDLE (cycle 0), arbitration:
  - Vdp wins if vdpReq=1 and cpuWait<MAX_CPU_WAIT.
  - Otherwise Cpu wins if cpuReq=1.
  - Otherwise Vdp wins if vdpReq=1.
  - With no request, the FSM stays in IDLE.
  - The winner's address, write flag and data are latched into the owner register.
- ISSUE (cycle 1): memAddress and memDataOut are driven from the owner register.
  - Cpu write: memWrite=1, except when ROM_PROTECT=1 and address[15:14]==2'b00, where memWrite=0.
  - Read: memRead=1.
  - All mem strobes are registered and high for exactly this one cycle.
- CAPTURE (cycle 2): memDataIn is registered into the owner's DataOut on reads. Writes leave the DataOut registers unchanged.
- ACK (cycle 3): the owner's Ack=1 for exactly one cycle. The other Ack stays 0, and Acks are never both high.
- Requesters drop Req by the cycle after Ack. A Req still high when the FSM returns to IDLE is treated as a new transaction.
- cpuWait counter, 8 bits:
  - Increments in every cycle where cpuReq=1 and the Cpu is not the current owner.
  - Saturates at MAX_CPU_WAIT.
  - Clears when the Cpu is granted.
- Simultaneous requests in IDLE: the Vdp wins unless cpuWait has reached MAX_CPU_WAIT. This bounds Cpu latency to at most MAX_CPU_WAIT+4 cycles beyond one Vdp transaction.
- Request inputs are ignored outside IDLE. Changes to address or data after the grant do not affect the latched transaction.
- memAddress and memDataOut hold their last values when idle. memRead and memWrite are 0 outside ISSUE.

Optional Feature:
- Macro: BUS_ARBITER_STATS_EN.
- When defined, the block adds these outputs:
  - cpuGrantCount (16-bit)
  - vdpGrantCount (16-bit)
  - cpuStallCount (16-bit)
- Counter behaviour:
  - All three clear on reset and saturate at 16'hFFFF.
  - The grant counters increment on each grant.
  - cpuStallCount increments on each cycle cpuWait increments.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cpu read only, cpuAddress=16'h4000, RAM[4000]=8'hA5 -> memRead pulses in cycle 1; cpuAck in cycle 3 with cpuDataOut=8'hA5; vdpAck stays 0.
- Cpu write 8'h3C to 16'h8001, then Cpu read of 16'h8001 -> memWrite pulses once with memDataOut=8'h3C; the read acks 8'h3C.
- ROM_PROTECT=1, Cpu write 8'hFF to 16'h0010 -> cpuAck in cycle 3; memWrite never asserts.
- vdpReq and cpuReq held high continuously, MAX_CPU_WAIT=8 -> Vdp wins the first two grants; the Cpu is granted in the IDLE where cpuWait=8; cpuWait then clears.
- Assert reset during CAPTURE of a Vdp read -> all outputs 0 immediately; no vdpAck; FSM in IDLE; a new request after reset completes normally in 4 cycles.
- With BUS_ARBITER_STATS_EN, 3 Cpu and 5 Vdp transactions -> cpuGrantCount=3, vdpGrantCount=5.
